smp_control_unit: RTL and testbench
===================================

Name: smp_control_unit

Overview:
- Fetch/decode/execute sequencer for the SMP. It drives the ALU's 7-bit select and the accumulator load enable.
- Owns PC, IR, AR and the zero flag.
- Fetches opcode and address bytes from an 8-bit memory with a ready handshake.
- Sits directly upstream of the ALU; the ALU result returns on alu_out for the zero flag.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- mem_addr  out  8  memory address
- mem_rd  out  1  read request, held until mem_ready
- mem_wr  out  1  write request, held until mem_ready
- mem_wdata  out  8  write data, equals ac
- mem_rdata  in  8  read data, valid when mem_ready=1
- mem_ready  in  1  transaction completes on a clock edge with ready=1
- ac  in  8  current accumulator value
- alu_out  in  8  ALU result
- alu_sel  out  7  ALU select
- ac_ld  out  1  accumulator loads alu_out at this edge
- zero  out  1  zero flag
- halted  out  1  in HALT state
- illegal  out  1  illegal opcode trapped (tied 0 without macro)
- pc  out  8  current PC (debug)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: PC=RESET_PC, IR=0, AR=0, zero=0, illegal=0, state=FETCH.
- Outputs during reset: mem_rd/mem_wr/ac_ld forced 0 while reset=1.
- Reset mid-operation: the in-flight transaction is abandoned. The first cycle after reset deasserts issues a fetch at RESET_PC.
- Opcode: IR[7:4]. 0 NOP, 1 LDAC a, 2 STAC a, 3 ADD a, 4 SUB a, 5 AND a, 6 OR a, 7 XOR a, 8 NOT, 9 INC, A CLAC, B JUMP a, C JMPZ a, F HALT. D/E are illegal. "a" is the next memory byte.
- alu_sel encoding: bit6=0 selects arithmetic on [3:0]:
  - 0000 clear, 0100 pass bus, 0101 add, 1001 inc, 1011 sub.
- alu_sel encoding: bit6=1 selects logic on [5:4]:
  - 00 and, 01 xor, 10 or, 11 not.
- alu_sel unused bits are 0. alu_sel is 0 when ac_ld=0.
- State FETCH: mem_addr=PC, mem_rd=1. On ready: IR<=mem_rdata, PC<=PC+1, go to DECODE.
- State DECODE:
  - NOT/INC/CLAC: ac_ld=1 with matching sel, then FETCH.
  - NOP: go to FETCH.
  - HALT: go to HALT.
  - Address-operand ops: go to ADDR.
- State ADDR: mem_addr=PC, mem_rd=1. On ready:
  - JUMP: PC<=rdata.
  - JMPZ: PC<=rdata if zero, else PC+1.
  - Other ops: AR<=rdata, PC<=PC+1.
  - Next state: FETCH for jumps, EXEC otherwise.
- State EXEC: mem_addr=AR.
  - STAC: mem_wr=1 until ready.
  - LDAC/ALU ops: mem_rd=1. In the ready cycle, ac_ld=1 with sel valid and bus=mem_rdata externally.
  - Then FETCH.
- State HALT: no requests; halted=1. Only reset exits.
- Zero flag: zero<=(alu_out==0) on every edge with ac_ld=1; unchanged otherwise.
- Latency with zero-wait memory:
  - NOP/NOT/INC/CLAC: 2 cycles.
  - JUMP/JMPZ: 3 cycles.
  - LDAC/STAC/ALU ops: 4 cycles.
  - Each wait cycle (ready=0) adds 1 cycle; address and control are held stable.
- Wrap-around: PC and AR wrap 8'hFF -> 8'h00.
- mem_ready while no request is ignored. mem_rd and mem_wr are never both 1.

Optional Feature:
- SMP_ILLEGAL_TRAP_EN defined: opcode D/E in DECODE sets illegal=1 (sticky until reset) and enters HALT.
- Undefined: D/E execute as NOP, and illegal is constant 0.

Decomposition:
- Package smp_pkg:
  - opcode constants;
  - ALU select constants (SEL_CLR, SEL_PASS, SEL_ADD, SEL_INC, SEL_SUB, SEL_AND, SEL_XOR, SEL_OR, SEL_NOT);
  - state encoding (FETCH, DECODE, ADDR, EXEC, HALT).
- Sub-module smp_decode: combinational map from IR[7:4] to alu_sel, needs_addr, is_store, is_jump, is_jmpz, is_halt, is_illegal.

Test Plan:
- Fetch-from-reset: memory holds 0x11,0x10 and M[0x10]=0x5A, zero-wait. Required: ac_ld=1 with alu_sel=0x04 in cycle 4; pc=0x02; zero=0.
- Wait states: ADD with mem_ready low 3 cycles on the operand read. Required: mem_addr and mem_rd stable throughout, and exactly one ac_ld pulse with alu_sel=0x05.
- Flag and branch, case 1: CLAC then JMPZ 0x40. Required: zero=1 and pc=0x40.
- Flag and branch, case 2: INC with ac=0xFF (alu_out=0x00) then JMPZ 0x40. Required: zero=1 and branch taken. With ac=0x01 the branch is not taken and PC skips the operand.
- STAC with ac=0x3C, AR=0x80. Required: mem_wr=1, mem_addr=0x80, mem_wdata=0x3C; mem_rd=0 throughout.
- Reset and wrap: reset asserted mid-EXEC, then released. Required: outputs idle during reset, next fetch at 0x00. Separately, NOP at 0xFF: next fetch at 0x00.
- HALT and illegal: 0xF0 gives halted=1 and no further requests. With SMP_ILLEGAL_TRAP_EN, 0xD0 gives illegal=1 and halted=1; without it, 0xD0 acts as NOP.

Source files
------------

// File: rtl/smp_pkg.sv
// Shared constants for the SMP control unit: opcodes, ALU select codes and
// sequencer state encoding.
package smp_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_CLAC = 4'hA;
  localparam logic [3:0] OP_JUMP = 4'hB;
  localparam logic [3:0] OP_JMPZ = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // bit6=0: arithmetic unit keyed on [3:0]; bit6=1: logic unit keyed on [5:4]
  localparam logic [6:0] SEL_CLR  = 7'b000_0000;
  localparam logic [6:0] SEL_PASS = 7'b000_0100;
  localparam logic [6:0] SEL_ADD  = 7'b000_0101;
  localparam logic [6:0] SEL_INC  = 7'b000_1001;
  localparam logic [6:0] SEL_SUB  = 7'b000_1011;
  localparam logic [6:0] SEL_AND  = 7'b100_0000;
  localparam logic [6:0] SEL_XOR  = 7'b101_0000;
  localparam logic [6:0] SEL_OR   = 7'b110_0000;
  localparam logic [6:0] SEL_NOT  = 7'b111_0000;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Opcodes that update the accumulator in DECODE without touching memory.
  function automatic logic is_implied(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_INC) || (op == OP_CLAC);
  endfunction

endpackage

// File: rtl/smp_decode.sv
// Combinational opcode decoder: maps IR[7:4] to the ALU select and the
// instruction class flags used by the sequencer.
module smp_decode
  import smp_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [6:0] alu_sel_o,
  output logic       needs_addr_o,
  output logic       is_store_o,
  output logic       is_jump_o,
  output logic       is_jmpz_o,
  output logic       is_halt_o,
  output logic       is_illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    alu_sel_o    = SEL_CLR;
    needs_addr_o = 1'b0;
    is_store_o   = 1'b0;
    is_jump_o    = 1'b0;
    is_jmpz_o    = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_LDAC: begin needs_addr_o = 1'b1; alu_sel_o = SEL_PASS; end
      OP_STAC: begin needs_addr_o = 1'b1; is_store_o = 1'b1;    end
      OP_ADD:  begin needs_addr_o = 1'b1; alu_sel_o = SEL_ADD;  end
      OP_SUB:  begin needs_addr_o = 1'b1; alu_sel_o = SEL_SUB;  end
      OP_AND:  begin needs_addr_o = 1'b1; alu_sel_o = SEL_AND;  end
      OP_OR:   begin needs_addr_o = 1'b1; alu_sel_o = SEL_OR;   end
      OP_XOR:  begin needs_addr_o = 1'b1; alu_sel_o = SEL_XOR;  end
      OP_NOT:  alu_sel_o = SEL_NOT;
      OP_INC:  alu_sel_o = SEL_INC;
      OP_CLAC: alu_sel_o = SEL_CLR;
      OP_JUMP: begin needs_addr_o = 1'b1; is_jump_o = 1'b1; end
      OP_JMPZ: begin needs_addr_o = 1'b1; is_jmpz_o = 1'b1; end
      OP_ILLD, OP_ILLE: is_illegal_o = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/smp_control_unit.sv
// SMP fetch/decode/execute sequencer: owns PC, IR, AR and the zero flag.
// Define SMP_ILLEGAL_TRAP_EN to trap opcodes D/E into HALT with a sticky flag.
module smp_control_unit
  import smp_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic [7:0] ac,
  input  logic [7:0] alu_out,
  output logic [6:0] alu_sel,
  output logic       ac_ld,
  output logic       zero,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] pc
);

  logic [2:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [3:0] ir_q, ir_d;   // only the opcode nibble of IR is ever consumed
  logic [7:0] ar_q, ar_d;
  logic       zero_q, zero_d;

  logic [7:0] addr_c;
  logic       rd_c, wr_c, ld_c;
  logic [6:0] sel_c;

  logic [6:0] dec_sel;
  logic       dec_needs_addr, dec_is_store, dec_is_jump, dec_is_jmpz;
  logic       dec_is_halt, dec_is_illegal;

`ifdef SMP_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  smp_decode u_decode (
    .opcode_i     (ir_q),
    .alu_sel_o    (dec_sel),
    .needs_addr_o (dec_needs_addr),
    .is_store_o   (dec_is_store),
    .is_jump_o    (dec_is_jump),
    .is_jmpz_o    (dec_is_jmpz),
    .is_halt_o    (dec_is_halt),
    .is_illegal_o (dec_is_illegal)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ar_d    = ar_q;
    addr_c  = pc_q;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    ld_c    = 1'b0;
    sel_c   = SEL_CLR;
`ifdef SMP_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      ST_FETCH: begin
        rd_c = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata[7:4];
          pc_d    = pc_q + 8'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_implied(ir_q)) begin
          ld_c    = 1'b1;
          sel_c   = dec_sel;
          state_d = ST_FETCH;
        end else if (dec_is_halt) begin
          state_d = ST_HALT;
`ifdef SMP_ILLEGAL_TRAP_EN
        end else if (dec_is_illegal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
`else
        end else if (dec_is_illegal) begin
          state_d = ST_FETCH;
`endif
        end else if (dec_needs_addr) begin
          state_d = ST_ADDR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_ADDR: begin
        rd_c = 1'b1;
        if (mem_ready) begin
          if (dec_is_jump) begin
            pc_d = mem_rdata;
          end else if (dec_is_jmpz) begin
            pc_d = zero_q ? mem_rdata : pc_q + 8'd1;
          end else begin
            ar_d = mem_rdata;
            pc_d = pc_q + 8'd1;
          end
          state_d = (dec_is_jump || dec_is_jmpz) ? ST_FETCH : ST_EXEC;
        end
      end
      ST_EXEC: begin
        addr_c = ar_q;
        wr_c   = dec_is_store;
        rd_c   = !dec_is_store;
        if (mem_ready) begin
          ld_c    = !dec_is_store;
          sel_c   = dec_sel;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
    zero_d = ld_c ? (alu_out == 8'h00) : zero_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ar_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ar_q    <= ar_d;
      zero_q  <= zero_d;
    end
  end

`ifdef SMP_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Requests are squashed during reset so an abandoned transaction never leaks.
  assign mem_addr  = addr_c;
  assign mem_rd    = rd_c & ~reset;
  assign mem_wr    = wr_c & ~reset;
  assign ac_ld     = ld_c & ~reset;
  assign alu_sel   = ac_ld ? sel_c : SEL_CLR;
  assign mem_wdata = ac;
  assign zero      = zero_q;
  assign halted    = (state_q == ST_HALT);
  assign pc        = pc_q;

endmodule

// File: tb/tb_smp_control_unit.sv
// Directed bench for smp_control_unit with a memory/ALU/accumulator model and
// a scoreboard of expected accumulator loads and memory writes.
module tb_smp_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, ac, alu_out, pc;
  logic       mem_rd, mem_wr, mem_ready, ac_ld, zero, halted, illegal;
  logic [6:0] alu_sel;

  logic [7:0] mem [256];
  logic [7:0] ac_set_val;
  logic       ac_set_en;

  typedef struct {
    logic       is_wr;
    logic [7:0] key;    // alu_sel for loads, address for writes
    logic [7:0] data;   // bus value for loads, write data for writes
    logic       chk_data;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  smp_control_unit #(.RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ac(ac), .alu_out(alu_out), .alu_sel(alu_sel),
    .ac_ld(ac_ld), .zero(zero), .halted(halted), .illegal(illegal), .pc(pc)
  );

  assign mem_rdata = mem[mem_addr];

  always_comb begin
    alu_out = 8'h00;
    case (alu_sel)
      7'h04: alu_out = mem_rdata;
      7'h05: alu_out = ac + mem_rdata;
      7'h09: alu_out = ac + 8'd1;
      7'h0B: alu_out = ac - mem_rdata;
      7'h40: alu_out = ac & mem_rdata;
      7'h50: alu_out = ac ^ mem_rdata;
      7'h60: alu_out = ac | mem_rdata;
      7'h70: alu_out = ~ac;
      default: alu_out = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (ac_set_en)  ac <= ac_set_val;
    else if (ac_ld) ac <= alu_out;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ld(input logic [7:0] sel, input logic [7:0] bus, input logic chk);
    sb_t e;
    e.is_wr = 1'b0; e.key = sel; e.data = bus; e.chk_data = chk;
    sb_q.push_back(e);
  endtask

  task automatic push_wr(input logic [7:0] addr, input logic [7:0] data);
    sb_t e;
    e.is_wr = 1'b1; e.key = addr; e.data = data; e.chk_data = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic sb_sample();
    sb_t e;
    if (ac_ld === 1'b1 || (mem_wr === 1'b1 && mem_ready === 1'b1)) begin
      check("sb_event_expected", 8'(sb_q.size() != 0), 8'h01);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.is_wr) begin
          check("sb_wr_kind", 8'(mem_wr), 8'h01);
          check("sb_wr_addr", mem_addr, e.key);
          check("sb_wr_data", mem_wdata, e.data);
        end else begin
          check("sb_ld_kind", 8'(ac_ld), 8'h01);
          check("sb_alu_sel", 8'(alu_sel), e.key);
          if (e.chk_data) check("sb_bus", mem_rdata, e.data);
        end
      end
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Samples just before the rising edge, then moves to the next falling edge.
  task automatic tick();
    #2;
    sb_sample();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset(input logic [7:0] ac_val);
    reset      = 1'b1;
    mem_ready  = 1'b1;
    ac_set_en  = 1'b1;
    ac_set_val = ac_val;
    settle();
    check("rst_mem_rd", 8'(mem_rd), 8'h00);
    check("rst_mem_wr", 8'(mem_wr), 8'h00);
    check("rst_ac_ld",  8'(ac_ld),  8'h00);
    @(negedge clk);
    ac_set_en = 1'b0;
    settle();
    check("rst_pc",      pc,            8'h00);
    check("rst_zero",    8'(zero),      8'h00);
    check("rst_halted",  8'(halted),    8'h00);
    check("rst_illegal", 8'(illegal),   8'h00);
    reset = 1'b0;
    settle();
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", 8'(halted), 8'h01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    mem_ready  = 1'b1;
    ac_set_en  = 1'b0;
    ac_set_val = 8'h00;
    clear_mem();
    @(negedge clk);

    // Fetch from reset: LDAC 0x10 with M[0x10]=0x5A, zero-wait memory
    clear_mem();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h10; mem[8'h10] = 8'h5A; mem[8'h02] = 8'hF0;
    do_reset(8'h00);
    push_ld(8'h04, 8'h5A, 1'b1);
    check("fetch_addr", mem_addr, 8'h00);
    check("fetch_rd", 8'(mem_rd), 8'h01);
    ticks(3);
    settle();
    check("ldac_ac_ld_c4", 8'(ac_ld), 8'h01);
    check("ldac_sel_c4", 8'(alu_sel), 8'h04);
    tick();
    settle();
    check("ldac_pc", pc, 8'h02);
    check("ldac_zero", 8'(zero), 8'h00);
    check("ldac_next_addr", mem_addr, 8'h02);
    wait_halt(5);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("halt_no_rd", 8'(mem_rd), 8'h00);
      check("halt_no_wr", 8'(mem_wr), 8'h00);
      tick();
    end
    check("halt_pc_frozen", pc, 8'h03);

    // Wait states: ADD 0x20 with ready low for 3 cycles on the operand read
    clear_mem();
    mem[8'h00] = 8'h31; mem[8'h01] = 8'h20; mem[8'h20] = 8'h11; mem[8'h02] = 8'hF0;
    do_reset(8'h5A);
    push_ld(8'h05, 8'h11, 1'b1);
    ticks(3);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("wait_rd", 8'(mem_rd), 8'h01);
      check("wait_addr", mem_addr, 8'h20);
      check("wait_no_ld", 8'(ac_ld), 8'h00);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    check("add_ac_ld", 8'(ac_ld), 8'h01);
    check("add_sel", 8'(alu_sel), 8'h05);
    tick();
    wait_halt(5);
    check("add_zero", 8'(zero), 8'h00);

    // CLAC then JMPZ 0x40: branch taken
    clear_mem();
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'hC0; mem[8'h02] = 8'h40;
    mem[8'h03] = 8'hF0; mem[8'h40] = 8'hF0;
    do_reset(8'h77);
    push_ld(8'h00, 8'h00, 1'b0);
    ticks(5);
    settle();
    check("clac_zero", 8'(zero), 8'h01);
    check("clac_jmpz_pc", pc, 8'h40);
    check("clac_jmpz_addr", mem_addr, 8'h40);
    wait_halt(5);

    // INC with ac=0xFF wraps to zero, JMPZ taken
    mem[8'h00] = 8'h90;
    do_reset(8'hFF);
    push_ld(8'h09, 8'h00, 1'b0);
    ticks(5);
    settle();
    check("inc_ff_zero", 8'(zero), 8'h01);
    check("inc_ff_pc", pc, 8'h40);
    wait_halt(5);

    // INC with ac=0x01, JMPZ not taken: PC skips the operand
    do_reset(8'h01);
    push_ld(8'h09, 8'h00, 1'b0);
    ticks(5);
    settle();
    check("inc_01_zero", 8'(zero), 8'h00);
    check("inc_01_pc", pc, 8'h03);
    check("inc_01_addr", mem_addr, 8'h03);
    wait_halt(5);

    // STAC 0x80 with ac=0x3C, one wait cycle on the write
    clear_mem();
    mem[8'h00] = 8'h20; mem[8'h01] = 8'h80; mem[8'h02] = 8'hF0;
    do_reset(8'h3C);
    push_wr(8'h80, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      check("stac_pre_no_wr", 8'(mem_wr), 8'h00);
      tick();
      settle();
    end
    mem_ready = 1'b0;
    settle();
    check("stac_wr", 8'(mem_wr), 8'h01);
    check("stac_no_rd", 8'(mem_rd), 8'h00);
    check("stac_addr", mem_addr, 8'h80);
    check("stac_wdata", mem_wdata, 8'h3C);
    check("stac_no_ld", 8'(ac_ld), 8'h00);
    tick();
    mem_ready = 1'b1;
    settle();
    check("stac_wr_held", 8'(mem_wr), 8'h01);
    check("stac_rd_held", 8'(mem_rd), 8'h00);
    tick();
    wait_halt(5);
    check("stac_zero", 8'(zero), 8'h00);

    // Reset asserted mid-EXEC of LDAC, with ready high during reset
    clear_mem();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h10; mem[8'h10] = 8'h22;
    do_reset(8'h00);
    ticks(3);
    mem_ready = 1'b0;
    settle();
    check("mid_exec_addr", mem_addr, 8'h10);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    settle();
    check("mid_rst_rd", 8'(mem_rd), 8'h00);
    check("mid_rst_wr", 8'(mem_wr), 8'h00);
    check("mid_rst_ld", 8'(ac_ld), 8'h00);
    check("mid_rst_sel", 8'(alu_sel), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    settle();
    check("mid_rst_fetch_addr", mem_addr, 8'h00);
    check("mid_rst_fetch_rd", 8'(mem_rd), 8'h01);
    check("mid_rst_pc", pc, 8'h00);
    check("mid_rst_zero", 8'(zero), 8'h00);

    // PC wrap: JUMP 0xFF, NOP at 0xFF, next fetch at 0x00
    clear_mem();
    mem[8'h00] = 8'hB0; mem[8'h01] = 8'hFF;
    do_reset(8'h00);
    ticks(3);
    settle();
    check("wrap_fetch_ff", mem_addr, 8'hFF);
    check("wrap_fetch_rd", 8'(mem_rd), 8'h01);
    tick();
    settle();
    check("wrap_pc", pc, 8'h00);
    tick();
    settle();
    check("wrap_next_fetch", mem_addr, 8'h00);
    check("wrap_next_rd", 8'(mem_rd), 8'h01);

    // Opcode 0xD0
    clear_mem();
    mem[8'h00] = 8'hD0; mem[8'h01] = 8'hF0;
    do_reset(8'h00);
    ticks(2);
    settle();
`ifdef SMP_ILLEGAL_TRAP_EN
    check("ill_halted", 8'(halted), 8'h01);
    check("ill_flag", 8'(illegal), 8'h01);
    check("ill_no_rd", 8'(mem_rd), 8'h00);
    tick();
    settle();
    check("ill_sticky", 8'(illegal), 8'h01);
    check("ill_still_no_rd", 8'(mem_rd), 8'h00);
`else
    check("d0_nop_halted", 8'(halted), 8'h00);
    check("d0_nop_illegal", 8'(illegal), 8'h00);
    check("d0_nop_fetch_rd", 8'(mem_rd), 8'h01);
    check("d0_nop_fetch_addr", mem_addr, 8'h01);
    wait_halt(4);
    check("d0_illegal_const", 8'(illegal), 8'h00);
`endif

    check("sb_drained", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
